// File: rtl/amp_power_seq_pkg.sv
// Shared constants for the amplifier power sequencer: sequencer state encoding,
// register write-data field positions and the watchdog period reset value.
package amp_power_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_WAIT_MV = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_ON      = 3'd3,
    ST_FAULT   = 3'd4
  } seq_state_e;

  // reg_wdata layout: per-channel enable value / mask pairs, power value / mask pair
  localparam int WD_EN_LSB       = 0;
  localparam int WD_MASK_LSB     = 8;
  localparam int WD_PWR_VAL_BIT  = 18;
  localparam int WD_PWR_MASK_BIT = 19;

  localparam logic [15:0] WDOG_PERIOD_RST = 16'h1680;

  function automatic logic is_powered(input seq_state_e s);
    return (s == ST_WAIT_MV) || (s == ST_SETTLE) || (s == ST_ON);
  endfunction

endpackage

// File: rtl/amp_power_seq_wdog_timer.sv
// Watchdog timer: free-running tick prescaler, saturating kick counter and the
// sticky timeout/warn flags. The warning comparator exists only with WDOG_WARN_EN.
module amp_power_seq_wdog_timer
  import amp_power_seq_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        any_wen_i,
  input  logic        timeout_wen_i,
  input  logic [15:0] period_wdata_i,
  input  logic        flag_clr_i,
  output logic        tick_o,
  output logic [15:0] period_o,
  output logic        timeout_o,
  output logic        warn_o
);

  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic [15:0]          period_q, period_d;
  logic [15:0]          count_q, count_d;
  logic                 timeout_q, timeout_d;
  logic                 tick;
  logic                 tick_live;

  // Tick fires on the cycle the prescaler is about to wrap back to zero.
  assign tick      = (presc_q == '1);
  assign tick_live = tick && !any_wen_i && (period_q != 16'd0);

  always_comb begin
    presc_d   = presc_q + 1'b1;
    period_d  = timeout_wen_i ? period_wdata_i : period_q;
    count_d   = count_q;
    timeout_d = timeout_q;
    if (any_wen_i || (period_q == 16'd0)) begin
      count_d = '0;
    end else if (tick) begin
      if (count_q < period_q) begin
        count_d = count_q + 16'd1;
      end else begin
        timeout_d = 1'b1;
      end
    end
    if (flag_clr_i) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      presc_q   <= '0;
      period_q  <= WDOG_PERIOD_RST;
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      period_q  <= period_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef WDOG_WARN_EN
  logic        warn_q, warn_d;
  logic [15:0] warn_thresh;

  assign warn_thresh = period_q - (period_q >> 2);

  always_comb begin
    warn_d = warn_q;
    if (tick_live && (count_q >= warn_thresh)) begin
      warn_d = 1'b1;
    end
    if (flag_clr_i) begin
      warn_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign warn_o = warn_q;
`else
  logic unused_tick_live;
  assign unused_tick_live = tick_live;
  assign warn_o           = 1'b0;
`endif

  assign tick_o    = tick;
  assign period_o  = period_q;
  assign timeout_o = timeout_q;

endmodule

// File: rtl/amp_power_seq.sv
// Amplifier power sequencer: brings the motor supply up, waits for it to settle,
// gates per-channel amp enables and forces amps off on watchdog timeout or fault.
// Optional WDOG_WARN_EN adds the watchdog early-warning flag.
module amp_power_seq
  import amp_power_seq_pkg::*;
#(
  parameter int NUM_CHAN         = 4,
  parameter int WDOG_DIV_WIDTH   = 8,
  parameter int MV_SETTLE_TICKS  = 7680,
  parameter int MV_TIMEOUT_TICKS = 19200
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic                status_wen,
  input  logic                timeout_wen,
  input  logic                any_wen,
  input  logic [31:0]         reg_wdata,
  input  logic                mv_good,
  input  logic [NUM_CHAN-1:0] safety_amp_disable,
  output logic [NUM_CHAN-1:0] amp_disable,
  output logic                pwr_enable,
  output logic [15:0]         wdog_period,
  output logic                wdog_timeout,
  output logic                wdog_warn,
  output logic [2:0]          seq_state,
  output logic                mv_fault
);

  localparam int CNT_MAX = (MV_SETTLE_TICKS > MV_TIMEOUT_TICKS) ? MV_SETTLE_TICKS
                                                                : MV_TIMEOUT_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  seq_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                fault_q, fault_d;
  logic [NUM_CHAN-1:0] dis_q, dis_d;
  logic [NUM_CHAN-1:0] amp_q, amp_d;
  logic                pwr_q, pwr_d;

  logic                pcmd, poff, flag_clr, tick;
  logic [NUM_CHAN-1:0] wr_en, wr_mask;
  logic                unused_wdata;

  assign wr_en    = reg_wdata[WD_EN_LSB +: NUM_CHAN];
  assign wr_mask  = reg_wdata[WD_MASK_LSB +: NUM_CHAN];
  assign pcmd     = status_wen & reg_wdata[WD_PWR_MASK_BIT] & reg_wdata[WD_PWR_VAL_BIT];
  assign poff     = status_wen & reg_wdata[WD_PWR_MASK_BIT] & ~reg_wdata[WD_PWR_VAL_BIT];
  assign flag_clr = pcmd | (status_wen & (|(wr_en & wr_mask)));

  assign unused_wdata = ^{reg_wdata[31:20], reg_wdata[17:16]};

  amp_power_seq_wdog_timer #(
    .DIV_WIDTH (WDOG_DIV_WIDTH)
  ) u_wdog_timer (
    .clk_i          (sysclk),
    .reset_i        (reset),
    .any_wen_i      (any_wen),
    .timeout_wen_i  (timeout_wen),
    .period_wdata_i (reg_wdata[15:0]),
    .flag_clr_i     (flag_clr),
    .tick_o         (tick),
    .period_o       (wdog_period),
    .timeout_o      (wdog_timeout),
    .warn_o         (wdog_warn)
  );

  // Sequencer next state; cnt_q counts ticks spent in WAIT_MV or SETTLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    unique case (state_q)
      ST_OFF: begin
        if (pcmd) begin
          state_d = ST_WAIT_MV;
          cnt_d   = '0;
        end
      end
      ST_WAIT_MV: begin
        if (mv_good) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CNT_W'(MV_TIMEOUT_TICKS - 1)) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_SETTLE: begin
        if (!mv_good) begin
          state_d = ST_WAIT_MV;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CNT_W'(MV_SETTLE_TICKS - 1)) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_ON: begin
        if (!mv_good) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end
      end
      ST_FAULT: begin
        if (pcmd) begin
          state_d = ST_WAIT_MV;
          fault_d = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
    if (poff) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end
  end

  // Safety and watchdog ORs are applied after the write so they always win.
  always_comb begin
    dis_d = dis_q;
    if (status_wen) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        dis_d[i] = (state_q != ST_ON) | (wr_mask[i] ? ~wr_en[i] : dis_q[i]);
      end
    end
    dis_d = dis_d | (wdog_timeout ? {NUM_CHAN{1'b1}} : safety_amp_disable);
    amp_d = dis_d | {NUM_CHAN{state_d != ST_ON}};
    pwr_d = is_powered(state_d);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      dis_q   <= '1;
      amp_q   <= '1;
      pwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      dis_q   <= dis_d;
      amp_q   <= amp_d;
      pwr_q   <= pwr_d;
    end
  end

  assign seq_state   = state_q;
  assign mv_fault    = fault_q;
  assign amp_disable = amp_q;
  assign pwr_enable  = pwr_q;

endmodule

// File: tb/tb_amp_power_seq.sv
// Self-checking bench for amp_power_seq: directed sequences, a vector table and
// randomized traffic compared every cycle against a behavioural model.
module tb_amp_power_seq;

  localparam int NC        = 4;
  localparam int DIVW      = 2;
  localparam int SETTLE_T  = 12;
  localparam int TIMEOUT_T = 20;
  localparam int TICK_CYC  = 1 << DIVW;

  localparam int S_OFF = 0, S_WAIT = 1, S_SETTLE = 2, S_ON = 3, S_FAULT = 4;
  localparam logic [31:0] PCMD = 32'h000C_0000;
  localparam logic [31:0] POFF = 32'h0008_0000;

  logic          sysclk = 1'b0;
  logic          reset, status_wen, timeout_wen, any_wen, mv_good;
  logic [31:0]   reg_wdata;
  logic [NC-1:0] safety_amp_disable, amp_disable;
  logic          pwr_enable, wdog_timeout, wdog_warn, mv_fault;
  logic [15:0]   wdog_period;
  logic [2:0]    seq_state;

  amp_power_seq #(
    .NUM_CHAN         (NC),
    .WDOG_DIV_WIDTH   (DIVW),
    .MV_SETTLE_TICKS  (SETTLE_T),
    .MV_TIMEOUT_TICKS (TIMEOUT_T)
  ) dut (
    .sysclk             (sysclk),
    .reset              (reset),
    .status_wen         (status_wen),
    .timeout_wen        (timeout_wen),
    .any_wen            (any_wen),
    .reg_wdata          (reg_wdata),
    .mv_good            (mv_good),
    .safety_amp_disable (safety_amp_disable),
    .amp_disable        (amp_disable),
    .pwr_enable         (pwr_enable),
    .wdog_period        (wdog_period),
    .wdog_timeout       (wdog_timeout),
    .wdog_warn          (wdog_warn),
    .seq_state          (seq_state),
    .mv_fault           (mv_fault)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  int            m_edges, m_state, m_wait_ticks, m_period, m_wcnt;
  bit            m_tick, m_to, m_warn, m_fault, m_pwr;
  logic [NC-1:0] m_dis, m_amp;

  task automatic model_edge();
    bit            pcmd, poff, clr;
    logic [NC-1:0] en, mask, nd;
    int            ns, nt, nw;
    bit            nto, nwarn, nf;
    if (reset) begin
      m_edges = 0; m_tick = 0; m_state = S_OFF; m_wait_ticks = 0;
      m_period = 'h1680; m_wcnt = 0; m_to = 0; m_warn = 0; m_fault = 0;
      m_dis = '1; m_amp = '1; m_pwr = 0;
      return;
    end
    m_edges++;
    m_tick = (m_edges % TICK_CYC) == 0;
    pcmd = status_wen && reg_wdata[19] && reg_wdata[18];
    poff = status_wen && reg_wdata[19] && !reg_wdata[18];
    en   = reg_wdata[NC-1:0];
    mask = reg_wdata[8 +: NC];
    clr  = pcmd || (status_wen && ((en & mask) != 0));
    // watchdog
    nw = m_wcnt; nto = m_to; nwarn = m_warn;
    if (any_wen || m_period == 0) nw = 0;
    else if (m_tick) begin
      if (m_wcnt < m_period) nw = m_wcnt + 1;
      else nto = 1;
`ifdef WDOG_WARN_EN
      if (m_wcnt >= m_period - m_period / 4) nwarn = 1;
`endif
    end
    if (clr) begin nto = 0; nwarn = 0; end
    // sequencer
    ns = m_state; nt = m_wait_ticks; nf = m_fault;
    case (m_state)
      S_OFF:   if (pcmd) begin ns = S_WAIT; nt = 0; end
      S_WAIT:
        if (mv_good) begin ns = S_SETTLE; nt = 0; end
        else if (m_tick) begin
          nt = m_wait_ticks + 1;
          if (nt == TIMEOUT_T) begin ns = S_FAULT; nf = 1; nt = 0; end
        end
      S_SETTLE:
        if (!mv_good) begin ns = S_WAIT; nt = 0; end
        else if (m_tick) begin
          nt = m_wait_ticks + 1;
          if (nt == SETTLE_T) begin ns = S_ON; nt = 0; end
        end
      S_ON:    if (!mv_good) begin ns = S_FAULT; nf = 1; end
      default: if (pcmd) begin ns = S_WAIT; nf = 0; nt = 0; end
    endcase
    if (poff) begin ns = S_OFF; nt = 0; end
    // per-channel disable
    nd = m_dis;
    if (status_wen)
      for (int i = 0; i < NC; i++) nd[i] = (m_state != S_ON) || (mask[i] ? !en[i] : m_dis[i]);
    nd = nd | (m_to ? {NC{1'b1}} : safety_amp_disable);
    if (timeout_wen) m_period = int'(reg_wdata[15:0]);
    m_wcnt = nw; m_to = nto; m_warn = nwarn;
    m_state = ns; m_wait_ticks = nt; m_fault = nf;
    m_dis = nd;
    m_amp = (ns == S_ON) ? nd : {NC{1'b1}};
    m_pwr = (ns == S_WAIT) || (ns == S_SETTLE) || (ns == S_ON);
  endtask

  task automatic check_model();
    chk("model_state",   32'(seq_state),    32'(m_state));
    chk("model_pwr",     32'(pwr_enable),   32'(m_pwr));
    chk("model_amp",     32'(amp_disable),  32'(m_amp));
    chk("model_fault",   32'(mv_fault),     32'(m_fault));
    chk("model_timeout", 32'(wdog_timeout), 32'(m_to));
    chk("model_warn",    32'(wdog_warn),    32'(m_warn));
    chk("model_period",  32'(wdog_period),  32'(m_period));
  endtask

  task automatic cyc();
    @(posedge sysclk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    status_wen = 0; timeout_wen = 0; any_wen = 0; reg_wdata = '0; safety_amp_disable = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; cyc(); cyc();
    reset = 0;
  endtask

  task automatic write_status(input logic [31:0] d);
    status_wen = 1; any_wen = 1; reg_wdata = d;
    cyc();
    idle_inputs();
  endtask

  task automatic write_timeout(input logic [15:0] p);
    timeout_wen = 1; any_wen = 1; reg_wdata = {16'h0, p};
    cyc();
    idle_inputs();
  endtask

  task automatic wait_state(input int st, input int budget, input string name);
    int n = 0;
    while (int'(seq_state) != st && n < budget) begin cyc(); n++; end
    chk(name, 32'(seq_state), 32'(st));
  endtask

  // Ticks consumed while the DUT stays in state st (bounded).
  task automatic count_ticks_in(input int st, output int ticks);
    int n = 0;
    ticks = 0;
    while (int'(seq_state) == st && n < 2000) begin
      cyc(); n++;
      if (m_tick) ticks++;
    end
  endtask

  typedef struct {
    logic          wen;
    logic [31:0]   data;
    logic [NC-1:0] safety;
    logic [NC-1:0] exp_amp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, n;
    vecs[0] = '{1'b1, 32'h0000_0F0F, 4'h0, 4'h0};
    vecs[1] = '{1'b1, 32'h0000_0101, 4'h1, 4'h1};
    vecs[2] = '{1'b0, 32'h0000_0000, 4'h0, 4'h1};
    vecs[3] = '{1'b1, 32'h0000_0100, 4'h0, 4'h1};
    vecs[4] = '{1'b1, 32'h0000_0301, 4'h0, 4'h2};
    vecs[5] = '{1'b1, 32'h0000_0C0C, 4'h0, 4'h2};
    vecs[6] = '{1'b0, 32'h0000_0000, 4'h8, 4'hA};
    vecs[7] = '{1'b1, 32'h0000_0F0F, 4'h0, 4'h0};
    vecs[8] = '{1'b1, 32'h0000_0F00, 4'h0, 4'hF};
    vecs[9] = '{1'b1, 32'h0000_0F05, 4'h0, 4'hA};

    reset = 1; mv_good = 0; idle_inputs();
    do_reset();
    chk("rst_state",   32'(seq_state),    32'(S_OFF));
    chk("rst_pwr",     32'(pwr_enable),   32'd0);
    chk("rst_amp",     32'(amp_disable),  32'hF);
    chk("rst_period",  32'(wdog_period),  32'h1680);
    chk("rst_timeout", 32'(wdog_timeout), 32'd0);
    chk("rst_warn",    32'(wdog_warn),    32'd0);
    chk("rst_fault",   32'(mv_fault),     32'd0);

    // Power-up with supply already good, then settle to ON
    mv_good = 1;
    write_status(PCMD);
    chk("pcmd_to_wait", 32'(seq_state), 32'(S_WAIT));
    chk("pcmd_pwr",     32'(pwr_enable), 32'd1);
    cyc();
    chk("wait_to_settle", 32'(seq_state), 32'(S_SETTLE));
    count_ticks_in(S_SETTLE, t);
    chk("settle_ticks", 32'(t), 32'(SETTLE_T));
    chk("settle_done_on", 32'(seq_state), 32'(S_ON));
    chk("on_amps_still_off", 32'(amp_disable), 32'hF);

    foreach (vecs[k]) begin
      status_wen = vecs[k].wen; any_wen = vecs[k].wen;
      reg_wdata = vecs[k].data; safety_amp_disable = vecs[k].safety;
      cyc();
      chk($sformatf("vec%0d_amp", k), 32'(amp_disable), 32'(vecs[k].exp_amp));
      idle_inputs();
    end

    // Watchdog expiry with a short period and no kicks
    write_status(32'h0000_0F0F);
    chk("wd_enable_all", 32'(amp_disable), 32'h0);
    write_timeout(16'd4);
    n = 0;
    while (!wdog_timeout && n < 200) begin cyc(); n++; end
    chk("wd_timeout_set", 32'(wdog_timeout), 32'd1);
    cyc(); cyc();
    chk("wd_amp_forced", 32'(amp_disable), 32'hF);
    chk("wd_pwr_kept",   32'(pwr_enable),  32'd1);
    chk("wd_state_on",   32'(seq_state),   32'(S_ON));
`ifdef WDOG_WARN_EN
    chk("wd_warn_set",   32'(wdog_warn),   32'd1);
`endif
    write_status(32'h0000_0101);
    chk("wd_flag_clear", 32'(wdog_timeout), 32'd0);
    write_timeout(16'd0);
    repeat (40) cyc();
    chk("wd_period0_no_timeout", 32'(wdog_timeout), 32'd0);

    // Supply drops mid-settle, then recovers
    do_reset();
    mv_good = 1;
    write_status(PCMD);
    cyc();
    t = 0; n = 0;
    while (t < 5 && n < 100) begin cyc(); n++; if (m_tick) t++; end
    mv_good = 0;
    cyc();
    chk("drop_to_wait", 32'(seq_state), 32'(S_WAIT));
    mv_good = 1;
    cyc();
    chk("resettle_enter", 32'(seq_state), 32'(S_SETTLE));
    count_ticks_in(S_SETTLE, t);
    chk("resettle_ticks", 32'(t), 32'(SETTLE_T));
    chk("resettle_on", 32'(seq_state), 32'(S_ON));

    // Supply never arrives: timeout to FAULT, next pcmd clears fault
    do_reset();
    mv_good = 0;
    write_status(PCMD);
    chk("nomv_wait", 32'(seq_state), 32'(S_WAIT));
    count_ticks_in(S_WAIT, t);
    chk("nomv_timeout_ticks", 32'(t), 32'(TIMEOUT_T));
    chk("nomv_fault_state", 32'(seq_state), 32'(S_FAULT));
    chk("nomv_fault_flag",  32'(mv_fault),  32'd1);
    chk("nomv_pwr_off",     32'(pwr_enable), 32'd0);
    write_status(PCMD);
    chk("refire_clears_fault", 32'(mv_fault),  32'd0);
    chk("refire_wait",         32'(seq_state), 32'(S_WAIT));
    write_status(POFF);
    chk("poff_state", 32'(seq_state), 32'(S_OFF));

    // Reset while ON beats simultaneous writes
    do_reset();
    mv_good = 1;
    write_status(PCMD);
    wait_state(S_ON, 200, "reach_on");
    write_timeout(16'h0022);
    write_status(32'h0000_0F0F);
    chk("pre_reset_amp", 32'(amp_disable), 32'h0);
    reset = 1; status_wen = 1; timeout_wen = 1; any_wen = 1; reg_wdata = PCMD | 32'h0F0F;
    cyc();
    idle_inputs(); reset = 0;
    chk("on_rst_state",  32'(seq_state),    32'(S_OFF));
    chk("on_rst_pwr",    32'(pwr_enable),   32'd0);
    chk("on_rst_amp",    32'(amp_disable),  32'hF);
    chk("on_rst_period", 32'(wdog_period),  32'h1680);
    chk("on_rst_to",     32'(wdog_timeout), 32'd0);

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      int r;
      logic [31:0] d;
      r = $urandom_range(0, 99);
      status_wen  = (r < 12);
      timeout_wen = (r >= 12 && r < 15);
      any_wen     = status_wen | timeout_wen | (r >= 95);
      d = '0;
      d[3:0]  = 4'($urandom_range(0, 15));
      d[11:8] = 4'($urandom_range(0, 15));
      d[19]   = ($urandom_range(0, 7) == 0);
      d[18]   = 1'($urandom_range(0, 1));
      if (timeout_wen) d[15:0] = 16'($urandom_range(0, 10));
      reg_wdata = d;
      safety_amp_disable = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      if ($urandom_range(0, 99) == 0) mv_good = ~mv_good;
      reset = ($urandom_range(0, 499) == 0);
      cyc();
    end
    idle_inputs(); reset = 0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
